// File: rtl/result_encoder_transmitter.sv
// Result encoder/transmitter: reads solver elements from RAM, run-length encodes
// their bits into PACKET_SIZE-bit packets, and sends 32-bit words to the CPU
// over a valid/ack handshake. Frame: size header, count header, data, trailer.
module result_encoder_transmitter #(
  parameter int unsigned ADDRESS_WIDTH = 13,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned PACKET_SIZE   = 8,
  parameter int unsigned BASE_ADDRESS  = 5007
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Encoding_Enable,
  input  logic [ADDRESS_WIDTH-1:0] Element_Count,
  output logic                     RAM_Read_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  input  logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic [31:0]              CPU_Bus,
  output logic                     Word_Valid,
  input  logic                     CPU_Ack,
  output logic                     Busy,
  output logic                     Done_Encoding
);

  localparam int unsigned K  = 32 / PACKET_SIZE;
  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [PACKET_SIZE-1:0] MAXRUN = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR0, S_HDR1, S_FETCH, S_WAIT_RAM, S_ENCODE, S_FLUSH, S_TRAILER, S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] count_q, count_d, idx_q, idx_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    sh_q, sh_d;
  logic [BW-1:0]            bits_q, bits_d;
  logic                     cur_q, cur_d;
  logic [PACKET_SIZE-1:0]   run_q, run_d;
  logic [15:0]              pkt_cnt_q, pkt_cnt_d;
  logic [31:0]              asm_q, asm_d, out_q, out_d;
  logic [CW-1:0]            asm_cnt_q, asm_cnt_d;
  logic                     out_vld_q, out_vld_d, trl_q, trl_d;

  // Per-cycle events handed from the datapath to the next-state logic
  logic hdr_ld_c, elem_end_c, last_c, flush_done_c, trl_sent_c;

  // Datapath next-state: handshake, packet assembly and run-length encoding
  always_comb begin
    logic                   out_free, xfer, move, emit, consume;
    logic [31:0]            asm_base;
    logic [CW-1:0]          cnt_base;
    logic [PACKET_SIZE-1:0] pkt;
    int unsigned            shamt;
    count_d = count_q; idx_d = idx_q; addr_d = addr_q; sh_d = sh_q; bits_d = bits_q;
    cur_d = cur_q; run_d = run_q; pkt_cnt_d = pkt_cnt_q; out_d = out_q;
    out_vld_d = out_vld_q; trl_d = trl_q;
    hdr_ld_c = 1'b0; elem_end_c = 1'b0; last_c = 1'b0; flush_done_c = 1'b0; trl_sent_c = 1'b0;
    emit = 1'b0; consume = 1'b0; pkt = '0; shamt = 0;

    out_free = !out_vld_q || CPU_Ack;
    xfer     = out_vld_q && CPU_Ack;
    move     = (asm_cnt_q == CW'(K)) && out_free;
    if (xfer) out_vld_d = 1'b0;
    if (move) begin
      out_d     = asm_q;
      out_vld_d = 1'b1;
    end
    asm_base  = move ? 32'd0 : asm_q;
    cnt_base  = move ? CW'(0) : asm_cnt_q;
    asm_d     = asm_base;
    asm_cnt_d = cnt_base;

    case (state_q)
      S_IDLE: if (Encoding_Enable) begin
        count_d = Element_Count; idx_d = '0; addr_d = ADDRESS_WIDTH'(BASE_ADDRESS);
        cur_d = 1'b0; run_d = '0; pkt_cnt_d = '0; asm_d = '0; asm_cnt_d = '0; trl_d = 1'b0;
      end
      S_HDR0: if (out_free) begin
        out_d = 32'(PACKET_SIZE); out_vld_d = 1'b1; hdr_ld_c = 1'b1;
      end
      S_HDR1: if (out_free) begin
        out_d = 32'(count_q); out_vld_d = 1'b1; hdr_ld_c = 1'b1;
      end
      S_WAIT_RAM: begin
        sh_d   = RAM_Data;
        bits_d = BW'(DATA_WIDTH);
      end
      S_ENCODE: if (cnt_base < CW'(K)) begin
        if (sh_q[DATA_WIDTH-1] == cur_q) begin
          if (run_q != MAXRUN) begin
            run_d = run_q + PACKET_SIZE'(1); consume = 1'b1;
          end else begin
            emit = 1'b1; pkt = run_q; cur_d = ~cur_q; run_d = '0;
          end
        end else begin
          emit = 1'b1; pkt = run_q; cur_d = sh_q[DATA_WIDTH-1];
          run_d = PACKET_SIZE'(1); consume = 1'b1;
        end
      end
      S_FLUSH: begin
        if (run_q != '0) begin
          if (cnt_base < CW'(K)) begin
            emit = 1'b1; pkt = run_q; run_d = '0;
          end
        end else if (cnt_base != '0 && cnt_base < CW'(K)) begin
          asm_cnt_d = CW'(K);
        end else if (asm_cnt_q == '0) begin
          flush_done_c = 1'b1;
        end
      end
      S_TRAILER: begin
        if (!trl_q && out_free) begin
          out_d = 32'(pkt_cnt_q); out_vld_d = 1'b1; trl_d = 1'b1;
        end
        if (trl_q && xfer) trl_sent_c = 1'b1;
      end
      default: ;
    endcase

    if (consume) begin
      sh_d   = sh_q << 1;
      bits_d = bits_q - BW'(1);
      if (bits_q == BW'(1)) begin
        elem_end_c = 1'b1;
        idx_d      = idx_q + ADDRESS_WIDTH'(1);
        addr_d     = addr_q + ADDRESS_WIDTH'(1);
        last_c     = (idx_q + ADDRESS_WIDTH'(1)) == count_q;
      end
    end
    if (emit) begin
      shamt     = 32 - PACKET_SIZE * (32'(cnt_base) + 1);
      asm_d     = asm_base | (32'(pkt) << shamt);
      asm_cnt_d = cnt_base + CW'(1);
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0; idx_q <= '0; addr_q <= ADDRESS_WIDTH'(BASE_ADDRESS);
      sh_q <= '0; bits_q <= '0; cur_q <= 1'b0; run_q <= '0; pkt_cnt_q <= '0;
      asm_q <= '0; asm_cnt_q <= '0; out_q <= '0; out_vld_q <= 1'b0; trl_q <= 1'b0;
    end else begin
      count_q <= count_d; idx_q <= idx_d; addr_q <= addr_d;
      sh_q <= sh_d; bits_q <= bits_d; cur_q <= cur_d; run_q <= run_d; pkt_cnt_q <= pkt_cnt_d;
      asm_q <= asm_d; asm_cnt_q <= asm_cnt_d; out_q <= out_d; out_vld_q <= out_vld_d; trl_q <= trl_d;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (Encoding_Enable) state_d = S_HDR0;
      S_HDR0:     if (hdr_ld_c) state_d = S_HDR1;
      S_HDR1:     if (hdr_ld_c) state_d = (count_q == '0) ? S_TRAILER : S_FETCH;
      S_FETCH:    state_d = S_WAIT_RAM;
      S_WAIT_RAM: state_d = S_ENCODE;
      S_ENCODE:   if (elem_end_c) state_d = last_c ? S_FLUSH : S_FETCH;
      S_FLUSH:    if (flush_done_c) state_d = S_TRAILER;
      S_TRAILER:  if (trl_sent_c) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state and datapath registers
  always_comb begin
    RAM_Read_Enable = (state_q == S_FETCH);
    Busy            = (state_q != S_IDLE);
    Done_Encoding   = (state_q == S_DONE);
    RAM_Address     = addr_q;
    CPU_Bus         = out_q;
    Word_Valid      = out_vld_q;
  end

endmodule

// File: tb/tb_result_encoder_transmitter.sv
// Directed bench for result_encoder_transmitter with a small RAM model and a
// word monitor; expected streams are hand-computed.
module tb_result_encoder_transmitter;

  localparam int BASE = 5007;

  logic        clk = 1'b0;
  logic        RST, Encoding_Enable, RAM_Read_Enable, Word_Valid, CPU_Ack, Busy, Done_Encoding;
  logic [12:0] Element_Count, RAM_Address;
  logic [63:0] RAM_Data;
  logic [31:0] CPU_Bus;

  always #5 clk = ~clk;

  result_encoder_transmitter dut (
    .CLK(clk), .RST(RST), .Encoding_Enable(Encoding_Enable), .Element_Count(Element_Count),
    .RAM_Read_Enable(RAM_Read_Enable), .RAM_Address(RAM_Address), .RAM_Data(RAM_Data),
    .CPU_Bus(CPU_Bus), .Word_Valid(Word_Valid), .CPU_Ack(CPU_Ack), .Busy(Busy),
    .Done_Encoding(Done_Encoding)
  );

  logic [63:0] mem [8];
  logic [31:0] words[$];
  logic [31:0] exp_w[$];
  int          reads[$];
  int          done_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  // RAM model: data one cycle after the strobe
  always @(posedge clk) begin
    if (RAM_Read_Enable) RAM_Data <= mem[3'(RAM_Address - 13'(BASE))];
  end

  // Monitor transfers, reads and done pulses
  always @(posedge clk) begin
    if (!RST) begin
      if (Word_Valid && CPU_Ack) words.push_back(CPU_Bus);
      if (RAM_Read_Enable) reads.push_back(int'(RAM_Address));
      if (Done_Encoding) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int cnt);
    words.delete(); reads.delete(); done_cnt = 0;
    @(negedge clk);
    Element_Count = 13'(cnt); Encoding_Enable = 1'b1;
    @(negedge clk);
    Encoding_Enable = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_nwords"}, 32'(words.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < words.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), words[i], exp_w[i]);
  endtask

  initial begin
    int          unstable, rd0;
    logic [31:0] ref_bus;
    RST = 1'b1; Encoding_Enable = 1'b0; Element_Count = '0; CPU_Ack = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(RAM_Address), 32'(BASE));
    chk("rst_outs", {26'd0, RAM_Read_Enable, Word_Valid, Busy, Done_Encoding, 2'b0}, 32'd0);
    chk("rst_bus", CPU_Bus, 32'd0);
    RST = 1'b0;
    @(negedge clk);

    // One zero element
    mem[0] = 64'h0;
    start_job(1); wait_done("zero");
    exp_w = '{32'h8, 32'h1, 32'h40000000, 32'h1}; cmp_stream("zero");

    // One all-ones element; a second start while busy must be ignored
    mem[0] = '1;
    start_job(1);
    repeat (4) @(negedge clk);
    Element_Count = 13'd3; Encoding_Enable = 1'b1; @(negedge clk); Encoding_Enable = 1'b0;
    wait_done("ones");
    exp_w = '{32'h8, 32'h1, 32'h00400000, 32'h2}; cmp_stream("ones");

    // Alternating bits
    mem[0] = 64'hAAAAAAAAAAAAAAAA;
    start_job(1); wait_done("alt");
    exp_w = '{32'h8, 32'h1, 32'h00010101};
    for (int i = 0; i < 15; i++) exp_w.push_back(32'h01010101);
    exp_w.push_back(32'h01000000); exp_w.push_back(32'h41);
    cmp_stream("alt");

    // Five zero elements: MAXRUN split and address sequence
    for (int i = 0; i < 5; i++) mem[i] = 64'h0;
    start_job(5); wait_done("z5");
    exp_w = '{32'h8, 32'h5, 32'hFF004100, 32'h3}; cmp_stream("z5");
    chk("z5_nreads", 32'(reads.size()), 32'd5);
    for (int i = 0; i < 5 && i < reads.size(); i++)
      chk($sformatf("z5_addr%0d", i), 32'(reads[i]), 32'(BASE + i));

    // Backpressure: two alternating elements, ack held low 20 cycles
    mem[0] = 64'hAAAAAAAAAAAAAAAA; mem[1] = 64'hAAAAAAAAAAAAAAAA;
    start_job(2);
    for (int i = 0; i < 500 && words.size() < 4; i++) @(negedge clk);
    chk("bp_reach", 32'(words.size() >= 4), 32'd1);
    CPU_Ack = 1'b0; rd0 = reads.size();
    repeat (3) @(negedge clk);
    ref_bus = CPU_Bus;
    chk("bp_valid", 32'(Word_Valid), 32'd1);
    unstable = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (Word_Valid !== 1'b1 || CPU_Bus !== ref_bus) unstable++;
    end
    chk("bp_stable", 32'(unstable), 32'd0);
    chk("bp_reads", 32'(reads.size() - rd0 <= 1), 32'd1);
    CPU_Ack = 1'b1;
    wait_done("bp");
    exp_w = '{32'h8, 32'h2, 32'h00010101};
    for (int i = 0; i < 31; i++) exp_w.push_back(32'h01010101);
    exp_w.push_back(32'h01000000); exp_w.push_back(32'h81);
    cmp_stream("bp");

    // Zero elements
    start_job(0); wait_done("cnt0");
    exp_w = '{32'h8, 32'h0, 32'h0}; cmp_stream("cnt0");
    chk("cnt0_reads", 32'(reads.size()), 32'd0);

    // Reset in the middle of encoding
    for (int i = 0; i < 5; i++) mem[i] = 64'h0;
    start_job(5);
    for (int i = 0; i < 200 && reads.size() == 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {27'd0, RAM_Read_Enable, Word_Valid, Busy, Done_Encoding, 1'b0}, 32'd0);
    chk("mid_rst_addr", 32'(RAM_Address), 32'(BASE));
    chk("mid_rst_bus", CPU_Bus, 32'd0);
    RST = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_nodone", 32'(done_cnt), 32'd0);
    mem[0] = 64'h0;
    start_job(1); wait_done("restart");
    exp_w = '{32'h8, 32'h1, 32'h40000000, 32'h1}; cmp_stream("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
